// File: rtl/gyro_bias_calibrator.sv
// gyro_bias_calibrator: settles, averages stationary gyro samples into a per-axis bias, then emits saturated bias-corrected rates.
// Optional deadband around zero when GYRO_BIAS_DEADBAND_EN is defined.
module gyro_bias_calibrator #(
    parameter int DATA_W           = 10,
    parameter int CAL_SAMPLES_LOG2 = 6,
    parameter int SETTLE_SAMPLES   = 16,
    parameter int DEADBAND         = 2
) (
    input  logic                     CLOCK_50,
    input  logic                     RST_N,
    input  logic                     DataValid,
    input  logic signed [DATA_W-1:0] GyroX,
    input  logic signed [DATA_W-1:0] GyroY,
    input  logic signed [DATA_W-1:0] GyroZ,
    input  logic                     Recalibrate,
    output logic signed [DATA_W-1:0] GyroXOut,
    output logic signed [DATA_W-1:0] GyroYOut,
    output logic signed [DATA_W-1:0] GyroZOut,
    output logic                     DataReady,
    output logic                     Calibrated
);
    localparam int AW = DATA_W + CAL_SAMPLES_LOG2;
    localparam int CAL_N = 1 << CAL_SAMPLES_LOG2;
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef GYRO_BIAS_DEADBAND_EN
    localparam logic signed [DATA_W-1:0] DB_POS = DATA_W'(DEADBAND);
    localparam logic signed [DATA_W-1:0] DB_NEG = -DB_POS;
`endif

    typedef enum logic [1:0] {SETTLE, ACCUM, RUN} stateType;
    stateType state, nextState;

    logic dvReg, evt, lastSettle, lastAccum;
    logic [31:0] count;
    logic signed [DATA_W-1:0] gyroIn [3];
    logic signed [DATA_W-1:0] sample [3];
    logic signed [DATA_W-1:0] bias [3];
    logic signed [DATA_W-1:0] sat [3];
    logic signed [DATA_W-1:0] corr [3];
    logic signed [DATA_W-1:0] outVal [3];
    logic signed [DATA_W:0] diff [3];
    logic signed [AW-1:0] acc [3];
    logic signed [AW-1:0] accSum [3];
    logic signed [AW-1:0] accShift [3];

    assign gyroIn[0] = GyroX;
    assign gyroIn[1] = GyroY;
    assign gyroIn[2] = GyroZ;
    assign GyroXOut = outVal[0];
    assign GyroYOut = outVal[1];
    assign GyroZOut = outVal[2];
    assign Calibrated = (state == RUN);

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) state <= SETTLE;
        else state <= nextState;
    end

    always_comb begin
        lastSettle = (SETTLE_SAMPLES == 0) || (evt && (count + 32'd1 == 32'(SETTLE_SAMPLES)));
        lastAccum = evt && (count + 32'd1 == 32'(CAL_N));
        nextState = Recalibrate ? SETTLE :
                    (state == SETTLE && lastSettle) ? ACCUM :
                    (state == ACCUM && lastAccum) ? RUN : state;
    end

    // Difference is formed one bit wider so overflow can be detected and clamped.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            accSum[i] = acc[i] + AW'(sample[i]);
            accShift[i] = accSum[i] >>> CAL_SAMPLES_LOG2;
            diff[i] = {sample[i][DATA_W-1], sample[i]} - {bias[i][DATA_W-1], bias[i]};
            sat[i] = (diff[i][DATA_W] != diff[i][DATA_W-1]) ? (diff[i][DATA_W] ? SAT_MIN : SAT_MAX) : diff[i][DATA_W-1:0];
`ifdef GYRO_BIAS_DEADBAND_EN
            corr[i] = (sat[i] >= DB_NEG && sat[i] <= DB_POS) ? '0 : sat[i];
`else
            corr[i] = sat[i];
`endif
        end
    end

    // Samples are captured on the detecting edge and consumed by the state logic one edge later.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            dvReg <= 1'b0;
            evt <= 1'b0;
            count <= '0;
            DataReady <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                sample[i] <= '0;
                acc[i] <= '0;
                bias[i] <= '0;
                outVal[i] <= '0;
            end
        end else begin
            dvReg <= DataValid;
            evt <= DataValid && !dvReg && !Recalibrate;
            DataReady <= 1'b0;
            if (DataValid && !dvReg) for (int i = 0; i < 3; i++) sample[i] <= gyroIn[i];
            if (Recalibrate) begin
                count <= '0;
                for (int i = 0; i < 3; i++) begin
                    acc[i] <= '0;
                    outVal[i] <= '0;
                end
            end else if (state == SETTLE) begin
                if (lastSettle) count <= '0;
                else if (evt) count <= count + 32'd1;
            end else if (state == ACCUM && evt) begin
                count <= lastAccum ? '0 : count + 32'd1;
                for (int i = 0; i < 3; i++) begin
                    acc[i] <= lastAccum ? '0 : accSum[i];
                    if (lastAccum) bias[i] <= accShift[i][DATA_W-1:0];
                end
            end else if (state == RUN && evt) begin
                DataReady <= 1'b1;
                for (int i = 0; i < 3; i++) outVal[i] <= corr[i];
            end
        end
    end
endmodule

// File: tb/tb_gyro_bias_calibrator.sv
// tb_gyro_bias_calibrator: directed checks of settle/accumulate/run, saturation, edge detect, reset and recalibration.
module tb_gyro_bias_calibrator;
    logic clk = 0, rstN = 0, dataValid = 0, recal = 0;
    logic signed [9:0] gx = 0, gy = 0, gz = 0;
    logic signed [9:0] ox, oy, oz;
    logic dataReady, calibrated;
    int checks = 0, failures = 0, readyCnt = 0;

    gyro_bias_calibrator #(.DATA_W(10), .CAL_SAMPLES_LOG2(2), .SETTLE_SAMPLES(2), .DEADBAND(2)) dut (
        .CLOCK_50(clk), .RST_N(rstN), .DataValid(dataValid),
        .GyroX(gx), .GyroY(gy), .GyroZ(gz), .Recalibrate(recal),
        .GyroXOut(ox), .GyroYOut(oy), .GyroZOut(oz),
        .DataReady(dataReady), .Calibrated(calibrated)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (dataReady) readyCnt++;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOut(input string tag, input int x, input int y, input int z);
        check({tag, "_x"}, ox, x);
        check({tag, "_y"}, oy, y);
        check({tag, "_z"}, oz, z);
    endtask

    task automatic sendSample(input int x, input int y, input int z);
        @(negedge clk);
        gx = 10'(x); gy = 10'(y); gz = 10'(z);
        dataValid = 1;
        repeat (3) @(negedge clk);
        dataValid = 0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic sendN(input int n, input int x, input int y, input int z);
        for (int i = 0; i < n; i++) sendSample(x, y, z);
    endtask

    task automatic pulseRecal();
        @(negedge clk);
        recal = 1;
        @(negedge clk);
        recal = 0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", dataReady, 0);
        check("rst_cal", calibrated, 0);
        checkOut("rst_out", 0, 0, 0);
        rstN = 1;

        sendN(5, 5, -3, 0);
        check("t1_cal_before", calibrated, 0);
        sendSample(5, -3, 0);
        check("t1_cal_after", calibrated, 1);
        check("t1_no_ready", readyCnt, 0);
        checkOut("t1_out_idle", 0, 0, 0);
        sendSample(15, -3, 7);
        check("t1_ready", readyCnt, 1);
        checkOut("t1_out", 10, 0, 7);

        pulseRecal();
        check("t2_recal_cal", calibrated, 0);
        checkOut("t2_recal_out", 0, 0, 0);
        sendN(2, 99, 99, 99);
        sendN(3, 1, 0, 0);
        sendSample(2, 0, 0);
        check("t2a_cal", calibrated, 1);
        sendSample(0, 0, 0);
        checkOut("t2a_out", -1, 0, 0);
        pulseRecal();
        sendN(2, 0, 0, 0);
        sendN(3, -1, 0, 0);
        sendSample(-2, 0, 0);
        sendSample(0, 0, 0);
        checkOut("t2b_out", 2, 0, 0);

        pulseRecal();
        sendN(6, -100, 0, 0);
        sendSample(450, 0, 0);
        checkOut("t3_sat_hi", 511, 0, 0);
        pulseRecal();
        sendN(6, 100, 0, 0);
        sendSample(-500, 0, 0);
        checkOut("t3_sat_lo", -512, 0, 0);

        base = readyCnt;
        @(negedge clk);
        gx = 0; gy = 0; gz = 0;
        dataValid = 1;
        repeat (50) @(negedge clk);
        dataValid = 0;
        repeat (2) @(negedge clk);
        #1;
        check("t4_one_pulse", readyCnt - base, 1);
        check("t4_out", ox, -100);

        pulseRecal();
        sendN(4, 50, 50, 50);
        @(negedge clk);
        rstN = 0;
        #1;
        check("t5_rst_cal", calibrated, 0);
        checkOut("t5_rst_out", 0, 0, 0);
        @(negedge clk);
        rstN = 1;
        sendN(6, 7, 8, -9);
        check("t5_cal", calibrated, 1);
        sendSample(17, 8, 0);
        checkOut("t5_out", 10, 0, 9);

        base = readyCnt;
        @(negedge clk);
        recal = 1; dataValid = 1; gx = 100; gy = 100; gz = 100;
        @(negedge clk);
        recal = 0;
        repeat (3) @(negedge clk);
        dataValid = 0;
        repeat (2) @(negedge clk);
        #1;
        check("t5_drop_ready", readyCnt - base, 0);
        check("t5_drop_cal", calibrated, 0);
        checkOut("t5_drop_out", 0, 0, 0);
        sendN(5, 3, 3, 3);
        check("t5_recal_5", calibrated, 0);
        sendSample(3, 3, 3);
        check("t5_recal_6", calibrated, 1);
        sendSample(4, 4, 4);
        checkOut("t5_recal_out", 1, 1, 1);

`ifdef GYRO_BIAS_DEADBAND_EN
        pulseRecal();
        sendN(6, 0, 0, 0);
        sendSample(2, -2, 3);
        checkOut("t6_db", 0, 0, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
